seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Mealy serial-pattern detector: compares a 1-bit input stream against a compile-time pattern of configurable length and flags each match combinationally in the cycle of its last bit. Overlapping or non-overlapping detection is selectable at run time. A saturating match counter is included. The block serves as the generic replacement for fixed-pattern detectors in the serial front-end, placed directly after the bit-sync stage.

## Interface
Parameters:
- SEQ_LEN, 4, pattern length in bits; legal range 2..16
- SEQ, 4'b1011, pattern; SEQ[SEQ_LEN-1] is the first bit received
- CNT_W, 8, match counter width; legal range 1..32

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  bit-valid qualifier; din is ignored when en=0
- din  input  1  serial data bit
- overlap  input  1  1: overlapping detection; 0: non-overlapping detection
- clr_cnt  input  1  synchronous clear of match_cnt
- dout  output  1  match flag, Mealy (combinational)
- match_cnt  output  CNT_W  saturating count of matches

## Operation
- The state is the number of pattern bits currently matched, S0..S(SEQ_LEN-1), encoded in $clog2(SEQ_LEN) bits. Reset state: S0.
- Expected bit in state Sk: SEQ[SEQ_LEN-1-k].
- en=1, din equals expected bit, k<SEQ_LEN-1: next state S(k+1); dout=0.
- en=1, din equals expected bit, k=SEQ_LEN-1: this is a match; dout=1.
  - Next state with overlap=0: S0.
  - Next state with overlap=1: S(f), where f is the length of the longest proper suffix of SEQ that is also a prefix of SEQ.
- en=1, din mismatch: next state is the length of the longest prefix of SEQ that is a suffix of the received bits so far plus din (KMP failure transition). Do not simply return to S0.
- en=0: state holds; dout=0.
- dout = en & (state==S(SEQ_LEN-1)) & (din==SEQ[0]) & ~rst.
- match_cnt behaviour:
  - clr_cnt=1: clears to 0. Clear has priority over increment in the same cycle.
  - Otherwise increments by 1 on each edge where dout=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- overlap is sampled only on the edge where a match occurs. Changing it in other cycles has no effect.
- The transition table is computed at elaboration from SEQ and SEQ_LEN; no runtime tables.

## Timing
- dout is asserted in the same cycle the final pattern bit is presented. Latency is 0 cycles from din.
- State and match_cnt update on the rising clk edge after the bit. match_cnt reflects a match one cycle after dout was high.
- Reset values:
  - state=S0
  - match_cnt=0
  - dout=0, forced while rst=1
- Reset mid-pattern: partial progress is discarded immediately. The first bit after rst deasserts is compared against SEQ[SEQ_LEN-1].
- Back-to-back matches with overlap=1 are supported. The minimum spacing is SEQ_LEN-f bits.
- Saturation boundary: at count 2^CNT_W-1, further matches leave the count unchanged. dout still pulses normally.

## Structure
- Package seq_det_pkg holds:
  - function seq_next(seq, len, k, bit) returning the next-state index
  - function seq_fail(seq, len) returning the overlap restart state f
  - the state-width helper
- Sub-module seq_det_sat_cnt contains the CNT_W saturating counter, with inc, clr and count ports. It is instantiated once.
- Top level contains the state register, the elaborated next-state logic and the dout equation.

## Test plan
All scenarios use SEQ=4'b1011 and SEQ_LEN=4 (f=1), with bits applied MSB-first and en=1 unless stated otherwise.
- overlap=0, stream 1,0,1,1,0,1,1 -> dout high on bit 4 only; match_cnt=1.
- overlap=1, same stream -> dout high on bits 4 and 7; match_cnt=2.
- Failure transition: stream 1,0,1,0,1,1 -> dout high on bit 6 (state S3→S2 on the 4th bit); match_cnt=1.
- en gaps: bits 1,0 then en=0 for 3 cycles with din toggling, then 1,1 -> dout high on the final bit; no dout while en=0.
- Reset mid-pattern: after 1,0,1, pulse rst asynchronously between edges -> dout=0 and match_cnt=0 immediately; then 1 -> no match; then 0,1,1 -> match.
- CNT_W=2: 5 matches -> match_cnt goes 1,2,3,3,3. Then assert clr_cnt in the same cycle as a sixth match -> match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector.
// All functions are evaluated at elaboration to build the transition table.
package seq_det_pkg;

  localparam int MAX_LEN = 16;

  function automatic int seq_w(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // Bit i of the pattern in arrival order (i=0 is received first).
  function automatic logic pat_bit(
    input logic [15:0] seq,
    input int          len,
    input int          i
  );
    logic [15:0] tmp;
    tmp = seq >> (len - 1 - i);
    return tmp[0];
  endfunction

  // KMP transition: k bits matched, then bit b arrives.
  function automatic int seq_next(
    input logic [15:0] seq,
    input int          len,
    input int          k,
    input logic        b
  );
    int   best;
    logic ok;
    logic r;
    best = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      if (l <= k + 1 && l <= len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < l) begin
            r = (k + 1 - l + j == k) ? b
              : pat_bit(seq, len, k + 1 - l + j);
            if (r != pat_bit(seq, len, j)) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  function automatic int seq_fail(
    input logic [15:0] seq,
    input int          len
  );
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < MAX_LEN; l++) begin
      if (l < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < l) begin
            if (pat_bit(seq, len, len - l + j) !=
                pat_bit(seq, len, j)) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear that wins over increment.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector with elaborated KMP transitions,
// run-time overlap select and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int          SW    = seq_w(SEQ_LEN);
  localparam int          NS    = 2 ** SW;
  localparam logic [15:0] SEQ_X = 16'(SEQ);
  localparam int          F     = seq_fail(SEQ_X, SEQ_LEN);

  localparam logic [SW-1:0] LAST = SW'(SEQ_LEN - 1);
  localparam logic [SW-1:0] F_ST = SW'(F);

  logic [SW-1:0] state;
  logic [SW-1:0] state_n;
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic          hit;

  // Unreachable encodings fall back to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam int N0 = (k < SEQ_LEN) ?
      seq_next(SEQ_X, SEQ_LEN, k, 1'b0) : 0;
    localparam int N1 = (k < SEQ_LEN) ?
      seq_next(SEQ_X, SEQ_LEN, k, 1'b1) : 0;
    assign nxt0[k] = N0[SW-1:0];
    assign nxt1[k] = N1[SW-1:0];
  end

  assign hit  = (state == LAST) && (din == SEQ[0]);
  assign dout = en & hit & ~rst;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (en && hit):  state_n = overlap ? F_ST : '0;
      (en && !hit): state_n = din ? nxt1[state] : nxt0[state];
      default:      state_n = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= state_n;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dout),
    .clr   (clr_cnt),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: default-width and 2-bit-counter detectors share stimulus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       dout8;
  logic       dout2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param u8 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .overlap   (overlap),
    .clr_cnt   (clr_cnt),
    .dout      (dout8),
    .match_cnt (cnt8)
  );

  seq_detector_param #(
    .SEQ_LEN (4),
    .SEQ     (4'b1011),
    .CNT_W   (2)
  ) u2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .overlap   (overlap),
    .clr_cnt   (clr_cnt),
    .dout      (dout2),
    .match_cnt (cnt2)
  );

  task automatic drive(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e;
    din = d;
    clr_cnt = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    din = 1'b1;
    #1;
    checks++;
    if (dout8 !== 1'b0 || cnt8 !== 8'd0) begin
      failures++;
      $display("FAIL reset: dout=%b cnt=%0d want 0 0", dout8, cnt8);
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_no_overlap();
    logic b [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic x [7] = '{0, 0, 0, 1, 0, 0, 0};
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, b[i], 1'b0);
      checks++;
      if (dout8 !== x[i]) begin
        failures++;
        $display("FAIL no_overlap bit%0d: dout=%b want %b", i + 1, dout8, x[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd1) begin
      failures++;
      $display("FAIL no_overlap cnt: got %0d want 1", cnt8);
    end
  endtask

  task automatic test_overlap();
    logic b [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic x [7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, b[i], 1'b0);
      checks++;
      if (dout8 !== x[i]) begin
        failures++;
        $display("FAIL overlap bit%0d: dout=%b want %b", i + 1, dout8, x[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd2) begin
      failures++;
      $display("FAIL overlap cnt: got %0d want 2", cnt8);
    end
  endtask

  task automatic test_fail_trans();
    logic b [6] = '{1, 0, 1, 0, 1, 1};
    logic x [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, b[i], 1'b0);
      checks++;
      if (dout8 !== x[i]) begin
        failures++;
        $display("FAIL fail_trans bit%0d: dout=%b want %b", i + 1, dout8, x[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd1) begin
      failures++;
      $display("FAIL fail_trans cnt: got %0d want 1", cnt8);
    end
  endtask

  task automatic test_en_gap();
    logic e [8] = '{1, 1, 0, 0, 0, 1, 0, 1};
    logic b [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
    logic x [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(e[i], b[i], 1'b0);
      checks++;
      if (dout8 !== x[i]) begin
        failures++;
        $display("FAIL en_gap step%0d: dout=%b want %b", i, dout8, x[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd1) begin
      failures++;
      $display("FAIL en_gap cnt: got %0d want 1", cnt8);
    end
  endtask

  task automatic test_reset_mid();
    logic b [4] = '{1, 0, 1, 1};
    logic x [4] = '{0, 0, 0, 1};
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    en = 1'b1;
    din = 1'b1;
    #1;
    checks++;
    if (dout8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid pre: dout=%b want 1", dout8);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dout8 !== 1'b0 || cnt8 !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid async: dout=%b cnt=%0d want 0 0", dout8, cnt8);
    end
    #1;
    rst = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b[i], 1'b0);
      checks++;
      if (dout8 !== x[i]) begin
        failures++;
        $display("FAIL reset_mid bit%0d: dout=%b want %b", i + 1, dout8, x[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] s = 16'b1011011011011011;
    logic [15:0] m = 16'b0001001001001001;
    int e8 = 0;
    int e2 = 0;
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, s[15-i], 1'b0);
      checks++;
      if (dout2 !== m[15-i] || int'(cnt8) != e8 || int'(cnt2) != e2) begin
        failures++;
        $display("FAIL saturate step%0d: dout=%b c8=%0d c2=%0d want %b %0d %0d",
                 i, dout2, cnt8, cnt2, m[15-i], e8, e2);
      end
      if (m[15-i]) begin
        e8++;
        if (e2 < 3) e2++;
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd5 || cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL saturate final: c8=%0d c2=%0d want 5 3", cnt8, cnt2);
    end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (dout2 !== 1'b1) begin
      failures++;
      $display("FAIL clr_match dout: got %b want 1", dout2);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL clr_priority: c8=%0d c2=%0d want 0 0", cnt8, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_no_overlap();
    test_overlap();
    test_fail_trans();
    test_en_gap();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
